// File: rtl/wb_bram_burst_if.sv
// wshb_if: Wishbone B4 bus bundle carrying its own clock and reset
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic        rty;
  modport master (
    input  clk, rst, dat_sm, ack, err, rty,
    output adr, dat_ms, sel, cti, bte, we, cyc, stb
  );
  modport slave (
    input  clk, rst, adr, dat_ms, sel, cti, bte, we, cyc, stb,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_bram_burst.sv
// wb_bram_burst: Wishbone slave block RAM with zero-wait incrementing/wrapping bursts
module wb_bram_burst #(
  parameter int MEM_ADR_WIDTH = 11,
  parameter bit BURST_EN      = 1'b1
) (
  wshb_if.slave wb_s
);
  localparam int AW = MEM_ADR_WIDTH;
  typedef enum logic {IDLE, BURST} state_t;
  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_q;
  logic [AW-1:0] badr_q, badr_d;
  logic [AW-1:0] idx, nxt;
  logic          req, in_range, cont, lin_oob, wr;
  logic          unused_adr;
  logic [31:0]   mem [2**AW];
  assign req        = wb_s.cyc & wb_s.stb;
  assign in_range   = wb_s.adr[31:AW+2] == '0;
  assign idx        = wb_s.adr[AW+1:2];
  assign unused_adr = ^wb_s.adr[1:0];
  assign cont       = BURST_EN && req && wb_s.cti == 3'b010 && (state_q == BURST || ack_q);
  assign lin_oob    = wb_s.bte == 2'b00 && &badr_q;
  assign nxt = wb_s.bte == 2'b00 ? badr_q + 1'b1 :
               wb_s.bte == 2'b01 ? {badr_q[AW-1:2], badr_q[1:0] + 2'd1} :
               wb_s.bte == 2'b10 ? {badr_q[AW-1:3], badr_q[2:0] + 3'd1} :
                                   {badr_q[AW-1:4], badr_q[3:0] + 4'd1};
  assign wr = req & wb_s.we & ack_q & in_range & ~wb_s.rst;
  assign wb_s.ack    = ack_q & ~wb_s.rst;
  assign wb_s.err    = err_q & ~wb_s.rst;
  assign wb_s.rty    = 1'b0;
  assign wb_s.dat_sm = wb_s.rst ? '0 : dat_q;
  // next state: continue an acked incrementing beat, else start a classic access after a quiet cycle
  always_comb begin
    state_d = IDLE;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    badr_d  = idx;
    if (cont) begin
      badr_d  = nxt;
      ack_d   = ~lin_oob;
      err_d   = lin_oob;
      state_d = lin_oob ? IDLE : BURST;
    end else if (state_q == IDLE && req && !ack_q && !err_q) begin
      ack_d = in_range;
      err_d = ~in_range;
    end
  end
  // state, response and read-data registers; badr_d is the word whose data appears next cycle
  always_ff @(posedge wb_s.clk) begin
    if (wb_s.rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      badr_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      badr_q  <= badr_d;
      dat_q   <= mem[badr_d];
    end
  end
  // byte-lane writes on acked write beats; contents survive reset
  always_ff @(posedge wb_s.clk) begin
    for (int i = 0; i < 4; i++)
      if (wr && wb_s.sel[i]) mem[idx][8*i +: 8] <= wb_s.dat_ms[8*i +: 8];
  end
endmodule

// File: tb/tb_wb_bram_burst.sv
// tb_wb_bram_burst: randomized self-checking bench for wb_bram_burst against a word-array model
module tb_wb_bram_burst;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] model [DEPTH];
  logic        ob_ack [17];
  logic        ob_err [17];
  logic [31:0] ob_dat [17];
  logic [31:0] wdata  [16];
  always #5 clk = ~clk;
  wshb_if bus (.clk(clk), .rst(rst));
  wb_bram_burst #(.MEM_ADR_WIDTH(AW), .BURST_EN(1'b1)) dut (.wb_s(bus.slave));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_bus();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0;
    bus.dat_ms = '0; bus.sel = '0; bus.cti = '0; bus.bte = '0;
  endtask
  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if ((a >> (AW + 2)) == 0) model[(a >> 2) % DEPTH] = (model[(a >> 2) % DEPTH] & ~m) | (d & m);
  endtask
  function automatic int beat_idx(input int st, input logic [1:0] b, input int k);
    int m;
    m = (b == 2'b00) ? 0 : (2 << b);
    return (m == 0) ? st + k : (st - st % m) + (st + k) % m;
  endfunction
  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output logic ga, output logic ge, output logic after, output int lat);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.adr = a; bus.dat_ms = d; bus.sel = s;
    bus.cti = 3'b000; bus.bte = 2'b00;
    lat = 0;
    do begin tick(); lat++; end while (!bus.ack && !bus.err && lat < 8);
    ga = bus.ack; ge = bus.err; rd = bus.dat_sm;
    tick();
    after = bus.ack | bus.err;
    idle_bus();
    tick();
  endtask
  task automatic run_burst(input logic w, input int st, input logic [1:0] b, input int n);
    int k;
    for (int i = 0; i < 17; i++) begin ob_ack[i] = 1'b0; ob_err[i] = 1'b0; ob_dat[i] = '0; end
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.bte = b; bus.sel = 4'hF;
    bus.adr = 32'(beat_idx(st, b, 0)) << 2; bus.cti = (n == 1) ? 3'b111 : 3'b010; bus.dat_ms = wdata[0];
    tick();
    for (k = 0; k < n; k++) begin
      bus.adr = 32'(beat_idx(st, b, k)) << 2;
      bus.cti = (k == n - 1) ? 3'b111 : 3'b010;
      bus.dat_ms = wdata[k];
      ob_ack[k] = bus.ack; ob_err[k] = bus.err; ob_dat[k] = bus.dat_sm;
      tick();
      if (ob_err[k] || !ob_ack[k]) break;
    end
    ob_ack[(k < n) ? k + 1 : n] = bus.ack;
    ob_err[(k < n) ? k + 1 : n] = bus.err;
    idle_bus();
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.cyc = 1'b1; bus.stb = 1'b1;
    tick(); tick();
    checks++;
    if (bus.ack !== 1'b0 || bus.err !== 1'b0 || bus.rty !== 1'b0 || bus.dat_sm !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b err=%b rty=%b dat=%h want 0 0 0 00000000", bus.ack, bus.err, bus.rty, bus.dat_sm);
    end
    rst = 1'b0;
    idle_bus();
    tick();
  endtask
  task automatic test_classic();
    logic [31:0] d; logic ga, ge, f; int l;
    classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, ga, ge, f, l);
    model_wr(32'h10, 32'hDEADBEEF, 4'hF);
    checks++;
    if (ga !== 1'b1 || ge !== 1'b0 || l != 1 || f !== 1'b0) begin
      errors++; $display("FAIL classic_write ack=%b err=%b lat=%0d after=%b want 1 0 1 0", ga, ge, l, f);
    end
    classic(1'b0, 32'h10, 32'h0, 4'hF, d, ga, ge, f, l);
    checks++;
    if (ga !== 1'b1 || l != 1 || f !== 1'b0 || d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL classic_read ack=%b lat=%0d after=%b dat=%h want 1 1 0 deadbeef", ga, l, f, d);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] r;
      r = $urandom;
      classic(1'b1, 32'(i) << 2, r, 4'hF, d, ga, ge, f, l);
      model_wr(32'(i) << 2, r, 4'hF);
      checks++;
      if (ga !== 1'b1 || ge !== 1'b0) begin
        errors++; $display("FAIL preload_ack word=%0d ack=%b err=%b want 1 0", i, ga, ge);
      end
    end
    for (int i = 0; i < 12; i++) begin
      int w;
      w = $urandom_range(0, DEPTH - 1);
      classic(1'b0, (32'(w) << 2) | 32'($urandom_range(0, 3)), 32'h0, 4'hF, d, ga, ge, f, l);
      checks++;
      if (ga !== 1'b1 || d !== model[w]) begin
        errors++; $display("FAIL random_read word=%0d ack=%b dat=%h want 1 %h", w, ga, d, model[w]);
      end
    end
  endtask
  task automatic test_byte_sel();
    logic [31:0] d; logic ga, ge, f; int l;
    classic(1'b1, 32'h14, 32'h0, 4'hF, d, ga, ge, f, l);
    model_wr(32'h14, 32'h0, 4'hF);
    classic(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, d, ga, ge, f, l);
    model_wr(32'h14, 32'hAABBCCDD, 4'b0101);
    classic(1'b0, 32'h14, 32'h0, 4'hF, d, ga, ge, f, l);
    checks++;
    if (d !== 32'h00BB00DD) begin
      errors++; $display("FAIL byte_sel_0101 dat=%h want 00bb00dd", d);
    end
    for (int i = 0; i < 8; i++) begin
      int w; logic [31:0] r; logic [3:0] s;
      w = $urandom_range(0, DEPTH - 1); r = $urandom; s = 4'($urandom_range(0, 15));
      classic(1'b1, 32'(w) << 2, r, s, d, ga, ge, f, l);
      model_wr(32'(w) << 2, r, s);
      classic(1'b0, 32'(w) << 2, 32'h0, 4'hF, d, ga, ge, f, l);
      checks++;
      if (d !== model[w]) begin
        errors++; $display("FAIL byte_sel_rand word=%0d sel=%b dat=%h want %h", w, s, d, model[w]);
      end
    end
  endtask
  task automatic test_back_to_back();
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'(7) << 2; bus.sel = 4'hF; bus.cti = 3'b000;
    for (int i = 0; i < 6; i++) begin
      logic e;
      tick();
      e = (i % 2 == 0);
      checks++;
      if (bus.ack !== e || bus.err !== 1'b0 || (e && bus.dat_sm !== model[7])) begin
        errors++; $display("FAIL back_to_back cyc=%0d ack=%b err=%b dat=%h want %b 0 %h", i, bus.ack, bus.err, bus.dat_sm, e, model[7]);
      end
    end
    idle_bus();
    tick();
  endtask
  task automatic test_burst();
    logic [31:0] d; logic ga, ge, f; int l;
    for (int i = 0; i < 4; i++) begin
      classic(1'b1, 32'(i) << 2, 32'(i), 4'hF, d, ga, ge, f, l);
      model_wr(32'(i) << 2, 32'(i), 4'hF);
    end
    for (int c = 0; c < 14; c++) begin
      logic w; logic [1:0] b; int st, n;
      w  = (c < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      b  = (c == 0) ? 2'b00 : (c == 1) ? 2'b01 : 2'($urandom_range(0, 3));
      st = (c == 0) ? 0 : (c == 1) ? 2 : $urandom_range(0, DEPTH - 1);
      n  = (c < 2) ? 4 : $urandom_range(1, 16);
      if (b == 2'b00 && st + n > DEPTH) st = DEPTH - n;
      for (int k = 0; k < 16; k++) wdata[k] = $urandom;
      run_burst(w, st, b, n);
      for (int k = 0; k < n; k++) begin
        int idx;
        idx = beat_idx(st, b, k);
        checks++;
        if (ob_ack[k] !== 1'b1 || ob_err[k] !== 1'b0) begin
          errors++; $display("FAIL burst_ack case=%0d beat=%0d ack=%b err=%b want 1 0", c, k, ob_ack[k], ob_err[k]);
        end
        if (!w) begin
          checks++;
          if (ob_dat[k] !== model[idx]) begin
            errors++; $display("FAIL burst_data case=%0d beat=%0d word=%0d dat=%h want %h", c, k, idx, ob_dat[k], model[idx]);
          end
        end else model[idx] = wdata[k];
      end
      checks++;
      if (ob_ack[n] !== 1'b0 || ob_err[n] !== 1'b0) begin
        errors++; $display("FAIL burst_end case=%0d ack=%b err=%b want 0 0", c, ob_ack[n], ob_err[n]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      int w;
      w = $urandom_range(0, DEPTH - 1);
      classic(1'b0, 32'(w) << 2, 32'h0, 4'hF, d, ga, ge, f, l);
      checks++;
      if (d !== model[w]) begin
        errors++; $display("FAIL burst_readback word=%0d dat=%h want %h", w, d, model[w]);
      end
    end
  endtask
  task automatic test_out_of_range();
    logic [31:0] d, a; logic ga, ge, f; int l;
    a = 32'(4) << (AW + 2);
    classic(1'b0, a, 32'h0, 4'hF, d, ga, ge, f, l);
    checks++;
    if (ga !== 1'b0 || ge !== 1'b1 || l != 1 || f !== 1'b0) begin
      errors++; $display("FAIL oob_read ack=%b err=%b lat=%0d after=%b want 0 1 1 0", ga, ge, l, f);
    end
    a = 32'($urandom) | 32'h8000_0000;
    classic(1'b1, a, 32'h5A5A_A5A5, 4'hF, d, ga, ge, f, l);
    model_wr(a, 32'h5A5A_A5A5, 4'hF);
    checks++;
    if (ga !== 1'b0 || ge !== 1'b1) begin
      errors++; $display("FAIL oob_write ack=%b err=%b want 0 1", ga, ge);
    end
    classic(1'b0, (a >> 2) % DEPTH << 2, 32'h0, 4'hF, d, ga, ge, f, l);
    checks++;
    if (d !== model[(a >> 2) % DEPTH]) begin
      errors++; $display("FAIL oob_no_write dat=%h want %h", d, model[(a >> 2) % DEPTH]);
    end
    run_burst(1'b0, DEPTH - 2, 2'b00, 4);
    checks++;
    if (ob_ack[0] !== 1'b1 || ob_dat[0] !== model[DEPTH-2] || ob_ack[1] !== 1'b1 || ob_dat[1] !== model[DEPTH-1]) begin
      errors++; $display("FAIL cross_beats ack=%b%b dat=%h %h want 11 %h %h", ob_ack[0], ob_ack[1], ob_dat[0], ob_dat[1], model[DEPTH-2], model[DEPTH-1]);
    end
    checks++;
    if (ob_ack[2] !== 1'b0 || ob_err[2] !== 1'b1) begin
      errors++; $display("FAIL cross_err ack=%b err=%b want 0 1", ob_ack[2], ob_err[2]);
    end
    checks++;
    if (ob_ack[3] !== 1'b0 || ob_err[3] !== 1'b0) begin
      errors++; $display("FAIL cross_after ack=%b err=%b want 0 0", ob_ack[3], ob_err[3]);
    end
  endtask
  task automatic test_reset_mid_burst();
    logic [31:0] d, n0, n1, old1; logic ga, ge, f; int l;
    n0 = $urandom; n1 = ~model[21]; old1 = model[21];
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.bte = 2'b00; bus.sel = 4'hF;
    bus.adr = 32'(20) << 2; bus.cti = 3'b010; bus.dat_ms = n0;
    tick();
    checks++;
    if (bus.ack !== 1'b1) begin
      errors++; $display("FAIL rst_burst_beat0 ack=%b want 1", bus.ack);
    end
    tick();
    bus.adr = 32'(21) << 2; bus.dat_ms = n1; rst = 1'b1;
    tick();
    checks++;
    if (bus.ack !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL rst_burst_abort ack=%b err=%b want 0 0", bus.ack, bus.err);
    end
    rst = 1'b0;
    idle_bus();
    tick();
    model_wr(32'(20) << 2, n0, 4'hF);
    classic(1'b0, 32'(20) << 2, 32'h0, 4'hF, d, ga, ge, f, l);
    checks++;
    if (ga !== 1'b1 || l != 1 || d !== model[20]) begin
      errors++; $display("FAIL rst_read_beat0 ack=%b lat=%0d dat=%h want 1 1 %h", ga, l, d, model[20]);
    end
    classic(1'b0, 32'(21) << 2, 32'h0, 4'hF, d, ga, ge, f, l);
    checks++;
    if (d !== old1) begin
      errors++; $display("FAIL rst_no_write dat=%h want %h", d, old1);
    end
  endtask
  initial begin
    idle_bus();
    test_reset();
    test_classic();
    test_byte_sel();
    test_back_to_back();
    test_burst();
    test_out_of_range();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
